mul16_mac_stage: RTL and testbench

//  Sequential multiply-accumulate stage built around multiply16_unsigned.
//  - Accepts a stream of 16-bit unsigned operand pairs over a valid/ready handshake.
//  - Registers each pair and drives it into the combinational multiplier.
//  - Sums the 32-bit products into a wide accumulator.
//  - On the beat marked last, presents the sum and term count downstream over a second valid/ready handshake.

---
 rtl/mul16_mac_pkg.sv | 13 +
 rtl/multiply16_unsigned.sv | 11 +
 rtl/mul16_mac_stage.sv | 118 +++++++++++
 tb/tb_mul16_mac_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul16_mac_pkg.sv
// Shared encodings and widths for the multiply-accumulate stage.
package mul16_mac_pkg;

  localparam int OPND_W = 16;
  localparam int PROD_W = 32;

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/multiply16_unsigned.sv
// Combinational unsigned multiplier; callers zero-extend 16-bit operands to 32 bits,
// so the 32-bit product is exact.
module multiply16_unsigned (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] p
);

  assign p = a * b;

endmodule

// File: rtl/mul16_mac_stage.sv
// Sequential multiply-accumulate stage: registered operand pair -> multiplier -> wide accumulator.
// Optional macro MAC_SATURATE_EN clamps the accumulator on overflow instead of wrapping.
module mul16_mac_stage
  import mul16_mac_pkg::*;
#(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPND_W-1:0]    in_a,
  input  logic [OPND_W-1:0]    in_b,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_acc,
  output logic [CNT_W-1:0]     out_count,
  output logic                 out_ovf,
  output state_t               dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid
  // never waits on ready, and the producer holds its data stable until the transfer.

  state_t              state, state_nxt;
  logic                s1_valid, s1_last;
  logic [OPND_W-1:0]   s1_a, s1_b;
  logic [PROD_W-1:0]   prod;
  logic [ACC_W:0]      sum_ext;
  logic                carry;
  logic [ACC_W-1:0]    acc, acc_nxt;
  logic [CNT_W-1:0]    count;
  logic                ovf, out_valid_q;
  logic                accept, out_fire;

  // in_ready is gated by rst_n so every output reads 0 while reset is held.
  assign in_ready  = rst_n && (state == ACC);
  assign accept    = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign dbg_state = state;

  multiply16_unsigned u_mul (
    .a ({{(32-OPND_W){1'b0}}, s1_a}),
    .b ({{(32-OPND_W){1'b0}}, s1_b}),
    .p (prod)
  );

  assign sum_ext = {1'b0, acc} + (ACC_W+1)'(prod);
  assign carry   = sum_ext[ACC_W];

`ifdef MAC_SATURATE_EN
  // Once clamped, the sum stays pinned at full scale until the result is taken.
  assign acc_nxt = (carry || ovf) ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
  assign acc_nxt = sum_ext[ACC_W-1:0];
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (accept && in_last) state_nxt = DRAIN;
      DRAIN:   if (s1_valid && s1_last) state_nxt = DONE;
      DONE:    if (out_fire) state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACC;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      out_valid_q <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a    <= in_a;
        s1_b    <= in_b;
        s1_last <= in_last;
      end
    end
  end

  // Result registers clear on the output handshake, ready for the next sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (out_fire) begin
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (s1_valid) begin
      acc   <= acc_nxt;
      count <= (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);
      ovf   <= ovf || carry;
    end
  end

  assign out_valid = out_valid_q;
  assign out_acc   = acc;
  assign out_count = count;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_mul16_mac_stage.sv
// Directed bench for mul16_mac_stage: vector table of sums plus hand-written
// backpressure, reset, overflow and count-saturation sequences.
module tb_mul16_mac_stage;
  import mul16_mac_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_ovf;
  logic [39:0] out_acc;
  logic [7:0]  out_count;
  state_t      dbg_state;

  logic        r33_in_ready, r33_out_valid, r33_out_ovf;
  logic [32:0] r33_out_acc;
  logic [7:0]  r33_out_count;
  state_t      r33_dbg_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mul16_mac_stage #(.ACC_W(40), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_acc(out_acc), .out_count(out_count),
    .out_ovf(out_ovf), .dbg_state(dbg_state)
  );

  // Narrow-accumulator copy sharing the same stimulus, used for overflow checks.
  mul16_mac_stage #(.ACC_W(33), .CNT_W(8)) u_dut33 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r33_in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(r33_out_valid),
    .out_ready(out_ready), .out_acc(r33_out_acc), .out_count(r33_out_count),
    .out_ovf(r33_out_ovf), .dbg_state(r33_dbg_state)
  );

  typedef struct {
    string       name;
    int          n;
    logic        gap;
    logic [15:0] a [4];
    logic [15:0] b [4];
    logic [39:0] exp_acc;
    logic [7:0]  exp_cnt;
    logic        exp_ovf;
  } sum_vec_t;

  sum_vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_beat(input logic [15:0] a, input logic [15:0] b, input logic last);
    int w;
    w = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) chk("in_ready_timeout", 64'(w), 64'd0);
    @(posedge clk);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk);
  endtask

  // Called right after the edge that accepted the last beat.
  task automatic wait_result(input string name, input logic [39:0] e_acc,
                             input logic [7:0] e_cnt, input logic e_ovf);
    int w;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk({name, "_drain_valid"}, 64'(out_valid), 64'd0);
    chk({name, "_drain_ready"}, 64'(in_ready), 64'd0);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!out_valid && w < 10);
    chk({name, "_latency"}, 64'(w), 64'd1);
    chk({name, "_acc"}, 64'(out_acc), 64'(e_acc));
    chk({name, "_count"}, 64'(out_count), 64'(e_cnt));
    chk({name, "_ovf"}, 64'(out_ovf), 64'(e_ovf));
  endtask

  task automatic ack(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_ack_valid"}, 64'(out_valid), 64'd0);
    chk({name, "_ack_ready"}, 64'(in_ready), 64'd1);
    chk({name, "_ack_acc"}, 64'(out_acc), 64'd0);
  endtask

  task automatic run_vec(input sum_vec_t v);
    for (int i = 0; i < v.n; i++) begin
      drive_beat(v.a[i], v.b[i], (i == v.n - 1));
      if (v.gap && i < v.n - 1) idle_cycle();
    end
    wait_result(v.name, v.exp_acc, v.exp_cnt, v.exp_ovf);
    ack(v.name);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{name:"single", n:1, gap:1'b0,
                a:'{16'h1111, 16'h0, 16'h0, 16'h0}, b:'{16'h0001, 16'h0, 16'h0, 16'h0},
                exp_acc:40'h1111, exp_cnt:8'd1, exp_ovf:1'b0};
    vecs[1] = '{name:"burst3", n:3, gap:1'b0,
                a:'{16'h1111, 16'h1111, 16'h1111, 16'h0}, b:'{16'h0011, 16'h0111, 16'h1111, 16'h0},
                exp_acc:40'h1369863, exp_cnt:8'd3, exp_ovf:1'b0};
    vecs[2] = '{name:"gapped", n:4, gap:1'b1,
                a:'{16'h0001, 16'h0002, 16'h0003, 16'h0004}, b:'{16'h0001, 16'h0001, 16'h0001, 16'h0001},
                exp_acc:40'hA, exp_cnt:8'd4, exp_ovf:1'b0};
    vecs[3] = '{name:"max_mix", n:2, gap:1'b0,
                a:'{16'hFFFF, 16'h8000, 16'h0, 16'h0}, b:'{16'hFFFF, 16'h0002, 16'h0, 16'h0},
                exp_acc:40'hFFFF0001, exp_cnt:8'd2, exp_ovf:1'b0};
    vecs[4] = '{name:"zero_term", n:1, gap:1'b0,
                a:'{16'h0000, 16'h0, 16'h0, 16'h0}, b:'{16'hABCD, 16'h0, 16'h0, 16'h0},
                exp_acc:40'h0, exp_cnt:8'd1, exp_ovf:1'b0};

    // Outputs during initial reset.
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_acc", 64'(out_acc), 64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    chk("rst_out_ovf", 64'(out_ovf), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ACC));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(in_ready), 64'd1);

    foreach (vecs[k]) run_vec(vecs[k]);

    // Backpressure: repeat the three-term burst and hold the result.
    drive_beat(16'h1111, 16'h0011, 1'b0);
    drive_beat(16'h1111, 16'h0111, 1'b0);
    drive_beat(16'h1111, 16'h1111, 1'b1);
    wait_result("bp", 40'h1369863, 8'd3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_acc", 64'(out_acc), 64'h1369863);
      chk("bp_hold_count", 64'(out_count), 64'd3);
    end
    ack("bp");
    drive_beat(16'h0002, 16'h0003, 1'b1);
    wait_result("bp_next", 40'd6, 8'd1, 1'b0);
    ack("bp_next");

    // Overflow: wide instance holds the exact sum, 33-bit instance overflows.
    drive_beat(16'hFFFF, 16'hFFFF, 1'b0);
    drive_beat(16'hFFFF, 16'hFFFF, 1'b0);
    drive_beat(16'hFFFF, 16'hFFFF, 1'b1);
    wait_result("ovf40", 40'h2FFFA0003, 8'd3, 1'b0);
    chk("ovf33_valid", 64'(r33_out_valid), 64'd1);
    chk("ovf33_count", 64'(r33_out_count), 64'd3);
    chk("ovf33_flag", 64'(r33_out_ovf), 64'd1);
`ifdef MAC_SATURATE_EN
    chk("ovf33_acc", 64'(r33_out_acc), 64'h1FFFFFFFF);
`else
    chk("ovf33_acc", 64'(r33_out_acc), 64'h0FFFA0003);
`endif
    ack("ovf");
    chk("ovf33_cleared", 64'(r33_out_ovf), 64'd0);

    // Reset mid-sum discards partial state.
    drive_beat(16'h0010, 16'h0010, 1'b0);
    drive_beat(16'h0010, 16'h0010, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_partial_acc", 64'(out_acc), 64'h100);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_acc", 64'(out_acc), 64'd0);
    chk("mid_rst_count", 64'(out_count), 64'd0);
    chk("mid_rst_ovf", 64'(out_ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_beat(16'h0002, 16'h0003, 1'b1);
    wait_result("after_rst", 40'd6, 8'd1, 1'b0);
    ack("after_rst");

    // Term count saturates rather than wrapping.
    for (int i = 0; i < 259; i++) drive_beat(16'h0001, 16'h0001, 1'b0);
    drive_beat(16'h0001, 16'h0001, 1'b1);
    wait_result("cnt_sat", 40'd260, 8'd255, 1'b0);
    ack("cnt_sat");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
